// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon-MM arbiter sharing the MIPS memory port; whole-transaction grants.
// Latency: request in ARB -> slave strobe next cycle; zero-wait access takes 2 cycles.
// Backpressure: owner sees slave waitrequest, the other master is held with waitrequest=1.
// Optional: define MIPS_ARB_ROUND_ROBIN_EN for round-robin ties (default: m0 always wins ties).
module mips_bus_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    output logic [1:0]          grant,
    output logic [CNT_W-1:0]    m0_count,
    output logic [CNT_W-1:0]    m1_count
);

    localparam logic [1:0] ST_ARB  = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last;       // master that completed most recently (1 = m1)
    logic       req0;
    logic       req1;
    logic       done0;
    logic       done1;
    logic       tie_to_m1;

    assign req0  = m0_read | m0_write;
    assign req1  = m1_read | m1_write;
    assign done0 = (state == ST_OWN0) & req0 & ~s_waitrequest;
    assign done1 = (state == ST_OWN1) & req1 & ~s_waitrequest;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    // Give the tie to whichever master was not served last.
    assign tie_to_m1 = ~last;
`else
    // Fixed priority: the CPU always wins; last is tracked but not consulted.
    logic unused_last;
    assign tie_to_m1   = 1'b0;
    assign unused_last = last;
`endif

    // Next-state selection: arbitrate in ARB, release on completion or abandoned request.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARB: begin
                if (req0 && req1)
                    state_nxt = tie_to_m1 ? ST_OWN1 : ST_OWN0;
                else if (req0)
                    state_nxt = ST_OWN0;
                else if (req1)
                    state_nxt = ST_OWN1;
                else
                    state_nxt = ST_ARB;
            end
            ST_OWN0: if (!req0 || !s_waitrequest) state_nxt = ST_ARB;
            ST_OWN1: if (!req1 || !s_waitrequest) state_nxt = ST_ARB;
            default: state_nxt = ST_ARB;
        endcase
    end

    // State, last-served flag and completion counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_ARB;
            last     <= 1'b1;
            m0_count <= '0;
            m1_count <= '0;
        end else begin
            state <= state_nxt;
            if (done0) begin
                m0_count <= m0_count + CNT_W'(1);
                last     <= 1'b0;
            end
            if (done1) begin
                m1_count <= m1_count + CNT_W'(1);
                last     <= 1'b1;
            end
        end
    end

    // Combinational routing: owner passes straight through, everyone else is stalled.
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        grant          = 2'b00;
        case (state)
            ST_OWN0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
                m0_readdata    = s_readdata;
                grant          = 2'b01;
            end
            ST_OWN1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
                m1_readdata    = s_readdata;
                grant          = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter (CNT_W=4 so counter wrap is reachable).
// Vector table for the basic single-master flows, directed sequences for corners, random vs model.
// Works with or without MIPS_ARB_ROUND_ROBIN_EN defined.
module tb_mips_bus_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] m0_address, m1_address, s_address;
    logic          m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [DW/8-1:0] m0_byteenable, m1_byteenable, s_byteenable;
    logic          m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
    logic [1:0]    grant;
    logic [CW-1:0] m0_count, m1_count;

    mips_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .m0_count(m0_count), .m1_count(m1_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (0 none, 1 m0, 2 m1), who was served last, completions.
    int mo;
    bit mlast;
    int mc0, mc1;

    function automatic bit rr_mode();
`ifdef MIPS_ARB_ROUND_ROBIN_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_check();
        bit own0, own1;
        own0 = (mo == 1);
        own1 = (mo == 2);
        chk("grant", grant, {own1, own0});
        chk("s_read", s_read, own0 ? m0_read : own1 ? m1_read : 1'b0);
        chk("s_write", s_write, own0 ? m0_write : own1 ? m1_write : 1'b0);
        chk("s_address", s_address, own0 ? m0_address : own1 ? m1_address : '0);
        chk("s_writedata", s_writedata, own0 ? m0_writedata : own1 ? m1_writedata : '0);
        chk("s_byteenable", s_byteenable, own0 ? m0_byteenable : own1 ? m1_byteenable : '0);
        chk("m0_waitrequest", m0_waitrequest, own0 ? s_waitrequest : 1'b1);
        chk("m1_waitrequest", m1_waitrequest, own1 ? s_waitrequest : 1'b1);
        chk("m0_readdata", m0_readdata, own0 ? s_readdata : '0);
        chk("m1_readdata", m1_readdata, own1 ? s_readdata : '0);
        chk("m0_count", m0_count, mc0);
        chk("m1_count", m1_count, mc1);
    endtask

    task automatic model_step();
        bit r0, r1;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (reset) begin
            mo = 0; mlast = 1'b1; mc0 = 0; mc1 = 0;
        end else if (mo == 0) begin
            if (r0 && r1)      mo = (rr_mode() && !mlast) ? 2 : 1;
            else if (r0)       mo = 1;
            else if (r1)       mo = 2;
        end else if (mo == 1) begin
            if (!r0) mo = 0;
            else if (!s_waitrequest) begin mc0 = (mc0 + 1) % (1 << CW); mlast = 1'b0; mo = 0; end
        end else begin
            if (!r1) mo = 0;
            else if (!s_waitrequest) begin mc1 = (mc1 + 1) % (1 << CW); mlast = 1'b1; mo = 0; end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_req(input bit r0, input bit w0, input bit r1, input bit w1, input bit sw);
        m0_read = r0; m0_write = w0; m1_read = r1; m1_write = w1; s_waitrequest = sw;
    endtask

    typedef struct {
        bit r0, w0, r1, w1, sw;
        logic [1:0] g;
        bit wr0, wr1, srd, swr;
        int c0, c1;
    } vec_t;

    vec_t tbl[12];
    int   gq[$];
    int   exp_g;

    initial begin
        // r0 w0 r1 w1 sw | grant wr0 wr1 srd swr c0 c1
        tbl[0]  = '{1,0,0,0,0, 2'b00, 1,1,0,0, 0,0};  // ARB, m0 read seen
        tbl[1]  = '{1,0,0,0,0, 2'b01, 0,1,1,0, 0,0};  // zero-wait completion
        tbl[2]  = '{0,0,0,0,0, 2'b00, 1,1,0,0, 1,0};
        tbl[3]  = '{0,0,0,1,1, 2'b00, 1,1,0,0, 1,0};  // m1 write requested
        tbl[4]  = '{0,0,0,1,1, 2'b10, 1,1,0,1, 1,0};  // stalled 3 cycles
        tbl[5]  = '{0,0,0,1,1, 2'b10, 1,1,0,1, 1,0};
        tbl[6]  = '{0,0,0,1,1, 2'b10, 1,1,0,1, 1,0};
        tbl[7]  = '{0,0,0,1,0, 2'b10, 1,0,0,1, 1,0};  // completes
        tbl[8]  = '{0,0,0,0,0, 2'b00, 1,1,0,0, 1,1};
        tbl[9]  = '{1,0,1,0,0, 2'b00, 1,1,0,0, 1,1};  // tie, last=m1 -> m0 in both modes
        tbl[10] = '{1,0,1,0,0, 2'b01, 0,1,1,0, 1,1};
        tbl[11] = '{1,0,1,0,0, 2'b00, 1,1,0,0, 2,1};

        mo = 0; mlast = 1'b1; mc0 = 0; mc1 = 0;
        reset = 1'b1;
        set_req(0, 0, 0, 0, 0);
        m0_address = 32'hBFC0_0000; m0_writedata = 32'h0; m0_byteenable = 4'hF;
        m1_address = 32'h0000_1000; m1_writedata = 32'h1234_5678; m1_byteenable = 4'b0011;
        s_readdata = 32'h2402_000A;
        to_pos();
        to_pos();
        reset = 1'b0;

        // Reset state
        to_neg();
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_read", s_read, 1'b0);
        chk("rst_wr0", m0_waitrequest, 1'b1);
        chk("rst_wr1", m1_waitrequest, 1'b1);
        chk("rst_m0_count", m0_count, 0);
        to_pos();

        // Vector table
        for (int i = 0; i < 12; i++) begin
            set_req(tbl[i].r0, tbl[i].w0, tbl[i].r1, tbl[i].w1, tbl[i].sw);
            to_neg();
            chk($sformatf("vec%0d_grant", i), grant, tbl[i].g);
            chk($sformatf("vec%0d_wr0", i), m0_waitrequest, tbl[i].wr0);
            chk($sformatf("vec%0d_wr1", i), m1_waitrequest, tbl[i].wr1);
            chk($sformatf("vec%0d_s_read", i), s_read, tbl[i].srd);
            chk($sformatf("vec%0d_s_write", i), s_write, tbl[i].swr);
            chk($sformatf("vec%0d_m0_count", i), m0_count, tbl[i].c0);
            chk($sformatf("vec%0d_m1_count", i), m1_count, tbl[i].c1);
            if (i == 1) begin
                chk("vec1_m0_readdata", m0_readdata, 32'h2402_000A);
                chk("vec1_s_address", s_address, 32'hBFC0_0000);
            end
            if (i >= 4 && i <= 7) begin
                chk($sformatf("vec%0d_s_address", i), s_address, 32'h0000_1000);
                chk($sformatf("vec%0d_s_writedata", i), s_writedata, 32'h1234_5678);
                chk($sformatf("vec%0d_s_be", i), s_byteenable, 4'b0011);
            end
            to_pos();
        end

        // Continuous contention for six transactions
        reset = 1'b1;
        set_req(0, 0, 0, 0, 0);
        to_pos();
        reset = 1'b0;
        set_req(1, 0, 1, 0, 0);
        for (int k = 0; k < 20 && gq.size() < 6; k++) begin
            to_neg();
            model_check();
            if (grant != 2'b00) gq.push_back(int'(grant));
            to_pos();
        end
        chk("contention_grants_seen", gq.size(), 6);
        for (int k = 0; k < gq.size(); k++) begin
            exp_g = (rr_mode() && (k % 2 == 1)) ? 2 : 1;
            chk($sformatf("contention_grant%0d", k), gq[k], exp_g);
        end
        set_req(0, 0, 0, 0, 0);
        to_neg();
        chk("contention_m0_count", m0_count, rr_mode() ? 3 : 6);
        chk("contention_m1_count", m1_count, rr_mode() ? 3 : 0);
        to_pos();

        // Reset while m1 owns the bus and the slave stalls
        set_req(0, 0, 0, 1, 1);
        to_neg(); chk("rstown_arb", grant, 2'b00); to_pos();
        to_neg(); chk("rstown_own1", grant, 2'b10); chk("rstown_swrite", s_write, 1'b1); to_pos();
        reset = 1'b1;
        to_neg(); chk("rstown_still_own", grant, 2'b10); to_pos();
        reset = 1'b0;
        to_neg();
        chk("rstown_swrite_drop", s_write, 1'b0);
        chk("rstown_grant", grant, 2'b00);
        chk("rstown_m0_count", m0_count, 0);
        chk("rstown_m1_count", m1_count, 0);
        to_pos();
        s_waitrequest = 1'b0;
        to_neg(); chk("reissue_grant", grant, 2'b10); chk("reissue_wr1", m1_waitrequest, 1'b0); to_pos();
        set_req(0, 0, 0, 0, 0);
        to_neg(); chk("reissue_m1_count", m1_count, 1); to_pos();

        // m0 abandons its read mid-stall, m1 pending
        set_req(1, 0, 1, 0, 1);
        to_neg(); model_check(); to_pos();
        to_neg(); chk("drop_own0", grant, 2'b01); chk("drop_wr1", m1_waitrequest, 1'b1); to_pos();
        set_req(0, 0, 1, 0, 1);
        to_neg(); chk("drop_cycle_grant", grant, 2'b01); chk("drop_s_read", s_read, 1'b0); to_pos();
        to_neg(); chk("drop_arb", grant, 2'b00); chk("drop_m0_count", m0_count, 0); to_pos();
        to_neg(); chk("drop_m1_granted", grant, 2'b10); to_pos();
        set_req(0, 0, 0, 0, 0);
        to_pos();

        // Counter wrap at 2^CW
        reset = 1'b1;
        to_pos();
        reset = 1'b0;
        set_req(1, 0, 0, 0, 0);
        for (int t = 0; t <= 16; t++) begin
            to_neg();
            chk($sformatf("wrap_count%0d", t), m0_count, t % 16);
            to_pos();
            to_neg();
            model_check();
            to_pos();
        end
        set_req(0, 0, 0, 0, 0);
        to_pos();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            m0_read  = ($urandom_range(0, 3) != 0);
            m0_write = ($urandom_range(0, 3) == 0);
            m1_read  = ($urandom_range(0, 2) == 0);
            m1_write = ($urandom_range(0, 2) == 0);
            s_waitrequest = ($urandom_range(0, 2) == 0);
            m0_address = $urandom; m1_address = $urandom;
            m0_writedata = $urandom; m1_writedata = $urandom;
            m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
            s_readdata = $urandom;
            to_neg();
            model_check();
            to_pos();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
